barrel_shifter_pipe: RTL and testbench
======================================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8 to 64 inclusive.
REQ-002 Parameter LOG2W, default 5, shift-amount width; SHALL equal log2(WIDTH); any other value SHALL be rejected at elaboration.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 in_valid  input  1  in_data/in_amt/in_mode hold a valid request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  LOG2W  shift amount, unsigned, 0 to WIDTH-1.
REQ-009 in_mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 out_valid  output  1  out_data/out_zero hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_zero  output  1  high when out_data is all zeros.

Function
REQ-014 The pipeline SHALL have LOG2W register stages; stage k SHALL shift by 2^k when bit k of the carried amount is 1, and pass through otherwise.
REQ-015 Each stage SHALL carry its valid bit, mode and the remaining amount bits alongside its data.
REQ-016 SLL: vacated LSBs SHALL be 0.
REQ-016a SRL: vacated MSBs SHALL be 0.
REQ-016b SRA: vacated MSBs SHALL equal in_data[WIDTH-1].
REQ-016c ROR: bits leaving the LSB end SHALL re-enter at the MSB end.
REQ-017 in_amt = 0 SHALL return in_data unchanged in every mode.
REQ-018 A request SHALL be accepted in a cycle when in_valid and in_ready are both 1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready); it SHALL not depend combinationally on in_valid.
REQ-020 When in_ready = 1, every stage SHALL advance by one; an empty slot (in_valid = 0) SHALL advance as a bubble with its valid bit 0.
REQ-021 When in_ready = 0, every stage register, including outputs, SHALL hold its value.
REQ-022 Latency: with no stall, out_valid for a request SHALL rise exactly LOG2W cycles after the acceptance edge.
REQ-023 Throughput SHALL be one request per cycle while out_ready is held at 1.
REQ-024 Results SHALL leave in acceptance order, each exactly once; none SHALL be lost or duplicated across stalls.
REQ-025 out_data and out_zero SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-026 out_zero SHALL be registered, computed in the final stage, and valid only when out_valid = 1.
REQ-027 Bubbles SHALL not be collapsed: a stall freezes the whole pipe, including empty stages.

Reset
REQ-028 While rst = 1 at a clock edge, all stage valid bits SHALL clear.
REQ-028a While rst = 1 at a clock edge, out_valid, out_data and out_zero SHALL go to 0, and all data, amount and mode registers SHALL go to 0.
REQ-029 rst SHALL take priority over a simultaneous accept or stall; in-flight requests SHALL be discarded and never appear at the output.
REQ-030 During and after reset, in_ready SHALL be 1 in the cycle following the reset edge, because out_valid = 0.

Verification (WIDTH=32 unless stated)
REQ-031 SLL 0x00000001 amt 31, out_ready=1 -> out_data 0x80000000, out_zero 0, out_valid exactly 5 cycles after accept.
REQ-032 SRA 0x80000000 amt 4 -> 0xF8000000; SRL same operands -> 0x08000000; ROR 0x12345678 amt 8 -> 0x78123456.
REQ-033 SRL 0x00000001 amt 1 -> out_data 0x00000000, out_zero 1; any mode, amt 0, 0xDEADBEEF -> 0xDEADBEEF.
REQ-034 Back-to-back requests, 10 accepted on consecutive cycles, out_ready low 3 cycles mid-stream -> in_ready low in exactly those cycles, 10 results in order, outputs stable while stalled.
REQ-035 3 requests in flight, rst pulsed for 1 cycle -> out_valid 0 from the next cycle, none of the 3 ever emerge, a new request afterwards returns with 5-cycle latency.
REQ-036 WIDTH=8, LOG2W=3: exhaustive sweep of all modes, amounts and data checked against a reference model -> zero mismatches, latency 3.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
// barrel_shifter_pipe
//
// Pipelined barrel shifter with a valid/ready handshake on both sides. It
// supports logical left, logical right, arithmetic right and rotate right.
// There is one register stage per bit of the shift amount. Stage k shifts
// by 2^k when bit k of the amount it carries is set. Otherwise it passes the
// data through unchanged. Back-pressure from the output freezes the whole
// pipe, including empty (bubble) stages.
//
// Parameters
//   WIDTH  data width, power of two from 8 to 64
//   LOG2W  shift-amount width, must equal log2(WIDTH)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request present on in_data/in_amt/in_mode
//   in_ready   block accepts a request this cycle
//   in_data    operand
//   in_amt     unsigned shift amount, 0 to WIDTH-1
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out_data/out_zero hold a result
//   out_ready  downstream takes the result this cycle
//   out_data   shifted result
//   out_zero   high when out_data is all zeros (registered)
// ============================================================================
module barrel_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int LOG2W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shiftMode_e;

    // Reject unsupported widths, or a mismatched amount width, while the
    // design is being elaborated rather than letting a broken pipe build.
    generate
        if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 ||
            LOG2W != $clog2(WIDTH)) begin : gBadParams
            $error("barrel_shifter_pipe: WIDTH must be a power of two in 8..64 and LOG2W must equal log2(WIDTH)");
        end
    endgenerate

    // Per-stage pipeline registers and their next-state values.
    logic [WIDTH-1:0] stageData_q  [LOG2W];
    logic [WIDTH-1:0] stageData_d  [LOG2W];
    logic [LOG2W-1:0] stageAmt_q   [LOG2W];
    logic [LOG2W-1:0] stageAmt_d   [LOG2W];
    logic [1:0]       stageMode_q  [LOG2W];
    logic [1:0]       stageMode_d  [LOG2W];
    logic             stageValid_q [LOG2W];
    logic             stageValid_d [LOG2W];
    logic             zero_q;
    logic             zero_d;

    // Walking values that feed each stage in the combinational loop.
    logic [WIDTH-1:0] curData;
    logic [LOG2W-1:0] curAmt;
    logic [1:0]       curMode;
    logic             curValid;

    // Shift one stage's worth: a fixed distance of 2^k in the given mode.
    // SRA takes its fill from the current MSB. Earlier stages keep the
    // original sign bit in place, so this matches the operand's sign.
    function automatic logic [WIDTH-1:0] shiftStage(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input int               k
    );
        int sh;
        sh = 1 << k;
        case (mode)
            MODE_SLL: return d << sh;
            MODE_SRL: return d >> sh;
            MODE_SRA: return $signed(d) >>> sh;
            MODE_ROR: return (d >> sh) | (d << (WIDTH - sh));
            default:  return d;
        endcase
    endfunction

    // The handshake is purely a function of the output side. A result
    // either is not present or is being taken, so the whole pipe can move.
    assign in_ready = !out_valid || out_ready;

    // Compute every stage's next contents. Stage 0 is fed from the input
    // port, and each later stage is fed from the register before it. The
    // full amount travels with the data so that each stage can pick out
    // its own bit. Bubbles flow through too, with their valid bit low.
    always_comb begin
        curData  = in_data;
        curAmt   = in_amt;
        curMode  = in_mode;
        curValid = in_valid;
        for (int k = 0; k < LOG2W; k++) begin
            stageData_d[k]  = curAmt[k] ? shiftStage(curData, curMode, k) : curData;
            stageAmt_d[k]   = curAmt;
            stageMode_d[k]  = curMode;
            stageValid_d[k] = curValid;
            curData  = stageData_q[k];
            curAmt   = stageAmt_q[k];
            curMode  = stageMode_q[k];
            curValid = stageValid_q[k];
        end
        zero_d = (stageData_d[LOG2W-1] == '0);
    end

    // Pipeline registers. Reset wins over everything and discards whatever
    // is in flight. Otherwise the pipe advances as a unit when ready and
    // holds completely when stalled, including empty stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LOG2W; k++) begin
                stageData_q[k]  <= '0;
                stageAmt_q[k]   <= '0;
                stageMode_q[k]  <= '0;
                stageValid_q[k] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (in_ready) begin
            for (int k = 0; k < LOG2W; k++) begin
                stageData_q[k]  <= stageData_d[k];
                stageAmt_q[k]   <= stageAmt_d[k];
                stageMode_q[k]  <= stageMode_d[k];
                stageValid_q[k] <= stageValid_d[k];
            end
            zero_q <= zero_d;
        end
    end

    assign out_valid = stageValid_q[LOG2W-1];
    assign out_data  = stageData_q[LOG2W-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
// tb_barrel_shifter_pipe
//
// Directed bench for barrel_shifter_pipe. It uses a 32-bit instance for the
// single-request, streaming, stall and reset scenarios. It uses an 8-bit
// instance for a full sweep of modes, amounts and data against a reference
// function. Latency is counted in clock edges, and the acceptance edge
// counts as the first edge.
// ============================================================================
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        inValid, inReady, outValid, outReady, outZero;
    logic [31:0] inData, outData;
    logic [4:0]  inAmt;
    logic [1:0]  inMode;

    logic        inValid8, inReady8, outValid8, outReady8, outZero8;
    logic [7:0]  inData8, outData8;
    logic [2:0]  inAmt8;
    logic [1:0]  inMode8;

    int checks = 0;
    int failures = 0;

    barrel_shifter_pipe #(.WIDTH(32), .LOG2W(5)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_amt(inAmt), .in_mode(inMode),
        .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .out_zero(outZero)
    );

    barrel_shifter_pipe #(.WIDTH(8), .LOG2W(3)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(inValid8), .in_ready(inReady8),
        .in_data(inData8), .in_amt(inAmt8), .in_mode(inMode8),
        .out_valid(outValid8), .out_ready(outReady8),
        .out_data(outData8), .out_zero(outZero8)
    );

    // Guard against a hung pipe so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-shift reference for the 8-bit sweep. It does not work stage by
    // stage: it performs the full shift in one step.
    function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        logic [15:0] wide;
        case (m)
            2'b00: return d << a;
            2'b01: return d >> a;
            2'b10: begin
                wide = {{8{d[7]}}, d};
                wide = wide >> a;
                return wide[7:0];
            end
            default: begin
                wide = {d, d};
                wide = wide >> a;
                return wide[7:0];
            end
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        inValid = 1'b0; inData = '0; inAmt = '0; inMode = '0; outReady = 1'b1;
        inValid8 = 1'b0; inData8 = '0; inAmt8 = '0; inMode8 = '0; outReady8 = 1'b1;
        tick();
        tick();
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", outValid); end
        checks++;
        if (outData !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=00000000", outData); end
        checks++;
        if (outZero !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_zero got=%0b exp=0", outZero); end
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", inReady); end
        checks++;
        if (outValid8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid8 got=%0b exp=0", outValid8); end
        rst = 1'b0;
        tick();
    endtask

    // One isolated request. Check its latency, data and zero flag, and
    // confirm that it leaves the pipe exactly once.
    task automatic test_single(input string name, input logic [31:0] d, input logic [4:0] a,
                               input logic [1:0] m, input logic [31:0] expD, input logic expZ);
        int cycles;
        outReady = 1'b1;
        inData = d; inAmt = a; inMode = m; inValid = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL %s_in_ready got=%0b exp=1", name, inReady); end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        cycles = 1;
        while (outValid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 5) begin failures++; $display("[TB] FAIL %s_latency got=%0d exp=5", name, cycles); end
        checks++;
        if (outData !== expD) begin failures++; $display("[TB] FAIL %s_data got=%h exp=%h", name, outData, expD); end
        checks++;
        if (outZero !== expZ) begin failures++; $display("[TB] FAIL %s_zero got=%0b exp=%0b", name, outZero, expZ); end
        tick();
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL %s_drained got=%0b exp=0", name, outValid); end
    endtask

    task automatic test_modes();
        test_single("sll31",     32'h00000001, 5'd31, 2'b00, 32'h80000000, 1'b0);
        test_single("sra4",      32'h80000000, 5'd4,  2'b10, 32'hF8000000, 1'b0);
        test_single("srl4",      32'h80000000, 5'd4,  2'b01, 32'h08000000, 1'b0);
        test_single("ror8",      32'h12345678, 5'd8,  2'b11, 32'h78123456, 1'b0);
        test_single("srl_zero",  32'h00000001, 5'd1,  2'b01, 32'h00000000, 1'b1);
        test_single("sll_amt0",  32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF, 1'b0);
        test_single("srl_amt0",  32'hDEADBEEF, 5'd0,  2'b01, 32'hDEADBEEF, 1'b0);
        test_single("sra_amt0",  32'hDEADBEEF, 5'd0,  2'b10, 32'hDEADBEEF, 1'b0);
        test_single("ror_amt0",  32'hDEADBEEF, 5'd0,  2'b11, 32'hDEADBEEF, 1'b0);
        test_single("ror_wrap",  32'h00000001, 5'd1,  2'b11, 32'h80000000, 1'b0);
        test_single("sra_pos",   32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000, 1'b1);
        test_single("sra_neg31", 32'hF0000000, 5'd31, 2'b10, 32'hFFFFFFFF, 1'b0);
        test_single("sll16",     32'hFFFFFFFF, 5'd16, 2'b00, 32'hFFFF0000, 1'b0);
    endtask

    // Ten requests streamed on consecutive cycles. The output is stalled
    // for three cycles once results are flowing.
    task automatic test_back_to_back();
        logic [31:0] vD [10] = '{32'h00000001, 32'h00000003, 32'h80000000, 32'hF0F0F0F0, 32'h80000000,
                                 32'h40000000, 32'h000000FF, 32'hABCD0000, 32'h12345678, 32'h80000001};
        logic [4:0]  vA [10] = '{5'd1, 5'd4, 5'd31, 5'd4, 5'd31, 5'd2, 5'd4, 5'd16, 5'd0, 5'd31};
        logic [1:0]  vM [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11};
        logic [31:0] vE [10] = '{32'h00000002, 32'h00000030, 32'h00000001, 32'h0F0F0F0F, 32'hFFFFFFFF,
                                 32'h10000000, 32'hF000000F, 32'h0000ABCD, 32'h12345678, 32'h00000003};
        int sent = 0;
        int got = 0;
        int iter = 0;
        logic stall;
        logic accept;
        logic [31:0] held = '0;
        while (got < 10 && iter < 60) begin
            stall = (iter >= 6 && iter <= 8);
            outReady = !stall;
            if (sent < 10) begin
                inValid = 1'b1; inData = vD[sent]; inAmt = vA[sent]; inMode = vM[sent];
            end else begin
                inValid = 1'b0;
            end
            #1;
            checks++;
            if (inReady !== !stall) begin failures++; $display("[TB] FAIL b2b_in_ready iter=%0d got=%0b exp=%0b", iter, inReady, !stall); end
            if (stall) begin
                if (iter == 6) begin
                    held = outData;
                end else begin
                    checks++;
                    if (outValid !== 1'b1 || outData !== held) begin
                        failures++;
                        $display("[TB] FAIL b2b_stall_stable iter=%0d got=%0b/%h exp=1/%h", iter, outValid, outData, held);
                    end
                end
            end
            if (outValid === 1'b1 && outReady) begin
                checks++;
                if (outData !== vE[got]) begin failures++; $display("[TB] FAIL b2b_result%0d got=%h exp=%h", got, outData, vE[got]); end
                got++;
            end
            accept = inValid && (inReady === 1'b1);
            @(posedge clk);
            #1;
            if (accept) sent++;
            iter++;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        checks++;
        if (got != 10) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=10", got); end
        tick();
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_extra_result got=%0b exp=0", outValid); end
    endtask

    // Three requests are in flight when a one-cycle reset hits. None may
    // surface afterwards, and a fresh request must still behave normally.
    task automatic test_reset_flush();
        logic sawValid = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1; inData = 32'h0000F000 + i; inAmt = 5'd4; inMode = 2'b01;
            tick();
        end
        inValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid got=%0b exp=0", outValid); end
        checks++;
        if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got=%0b exp=1", inReady); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (outValid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_ghost_result got=%0b exp=0", sawValid); end
        test_single("post_reset", 32'h0000F0F0, 5'd4, 2'b00, 32'h000F0F00, 1'b0);
    endtask

    // Every mode, amount and data value through the 8-bit pipe, streamed at
    // full rate.
    task automatic test_sweep8();
        logic [7:0] expQ [$];
        logic [7:0] e;
        int n = 0;
        int iter = 0;
        int firstValid = -1;
        outReady8 = 1'b1;
        while ((n < 8192 || expQ.size() > 0) && iter < 8300) begin
            if (n < 8192) begin
                inValid8 = 1'b1; inMode8 = n[12:11]; inAmt8 = n[10:8]; inData8 = n[7:0];
            end else begin
                inValid8 = 1'b0;
            end
            #1;
            if (outValid8 === 1'b1) begin
                if (firstValid < 0) firstValid = iter;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sweep8_unexpected iter=%0d got=%h exp=none", iter, outData8);
                end else begin
                    e = expQ.pop_front();
                    if (outData8 !== e || outZero8 !== (e == 8'h00)) begin
                        failures++;
                        $display("[TB] FAIL sweep8_result iter=%0d got=%h/%0b exp=%h/%0b", iter, outData8, outZero8, e, (e == 8'h00));
                    end
                end
            end
            if (inValid8 && inReady8 === 1'b1) begin
                expQ.push_back(ref8(inData8, inAmt8, inMode8));
                n++;
            end
            tick();
            iter++;
        end
        inValid8 = 1'b0;
        checks++;
        if (firstValid != 3) begin failures++; $display("[TB] FAIL sweep8_latency got=%0d exp=3", firstValid); end
        checks++;
        if (n != 8192 || expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL sweep8_complete got=%0d/%0d exp=8192/0", n, expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_flush();
        test_sweep8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
